// File: rtl/osc_pkg.sv
// ----------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the oscillator voice scheduler:
//   - state_e      : scheduler FSM states
//   - WF_*         : waveform codes understood by the phase-to-amplitude converter
//   - *_DEF        : default sizing constants
// ----------------------------------------------------------------------------
package osc_pkg;

  localparam int NUM_VOICES_DEF = 4;
  localparam int PHASE_W_DEF    = 32;
  localparam int AMP_W_DEF      = 12;

  // Waveform codes; anything not listed below is treated as sawtooth.
  localparam logic [2:0] WF_SAW  = 3'b000;
  localparam logic [2:0] WF_SQ50 = 3'b001;
  localparam logic [2:0] WF_SQ35 = 3'b010;
  localparam logic [2:0] WF_SQ15 = 3'b011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ACCUM   = 2'd2,
    OUTPUT  = 2'd3
  } state_e;

endpackage

// File: rtl/osc_voice_regfile.sv
// ----------------------------------------------------------------------------
// osc_voice_regfile
// Per-voice state: phase accumulator, phase increment, waveform code, enable.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_we/cfg_voice/...       config write port (takes effect next edge)
//   rd_idx                     voice being scheduled
//   rd_phase/rd_waveform/
//   rd_enable                  combinational read of voice rd_idx
//   adv_stb                    advance phase[rd_idx] by incr[rd_idx]
// A config write that disables a voice clears its phase, and that clear
// overrides an advance of the same voice on the same edge.
// ----------------------------------------------------------------------------
module osc_voice_regfile
  import osc_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [VIDX_W-1:0]  cfg_voice,
  input  logic [PHASE_W-1:0] cfg_incr,
  input  logic [2:0]         cfg_waveform,
  input  logic               cfg_enable,
  input  logic [VIDX_W-1:0]  rd_idx,
  output logic [PHASE_W-1:0] rd_phase,
  output logic [2:0]         rd_waveform,
  output logic               rd_enable,
  input  logic               adv_stb
);

  logic [PHASE_W-1:0] phase_q    [NUM_VOICES];
  logic [PHASE_W-1:0] incr_q     [NUM_VOICES];
  logic [2:0]         waveform_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] enable_q;

  logic [NUM_VOICES-1:0] wr_hit;
  logic [NUM_VOICES-1:0] adv_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_hit
      assign wr_hit[gi]  = cfg_we && (cfg_voice == VIDX_W'(gi));
      assign adv_hit[gi] = adv_stb && (rd_idx == VIDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i]    <= '0;
        incr_q[i]     <= '0;
        waveform_q[i] <= '0;
      end
      enable_q <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (wr_hit[i]) begin
          incr_q[i]     <= cfg_incr;
          waveform_q[i] <= cfg_waveform;
          enable_q[i]   <= cfg_enable;
        end
        // Disabling wins over a same-edge advance so a re-enabled voice
        // always restarts from phase 0.
        if (wr_hit[i] && !cfg_enable) begin
          phase_q[i] <= '0;
        end else if (adv_hit[i]) begin
          phase_q[i] <= phase_q[i] + incr_q[i];
        end
      end
    end
  end

  assign rd_phase    = phase_q[rd_idx];
  assign rd_waveform = waveform_q[rd_idx];
  assign rd_enable   = enable_q[rd_idx];

endmodule

// File: rtl/osc_voice_scheduler.sv
// ----------------------------------------------------------------------------
// osc_voice_scheduler
// Time-multiplexes one external phase-to-amplitude converter over
// NUM_VOICES voices. Each sample_tick walks all voices (PRESENT then ACCUM
// per voice), sums the enabled amplitudes and emits the mix with a
// one-cycle mix_valid pulse.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sample_tick       start-of-frame pulse
//   cfg_*             per-voice config write port
//   pa_phase/
//   pa_waveform       registered request to the converter
//   pa_amplitude      combinational converter answer
//   mix_out/mix_valid summed mix and its strobe
//   busy              frame in progress
//   overrun/
//   overrun_clr       sticky "tick while busy" flag and its clear
// ----------------------------------------------------------------------------
module osc_voice_scheduler
  import osc_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int AMP_W      = AMP_W_DEF,
  localparam int VIDX_W    = $clog2(NUM_VOICES),
  localparam int MIX_W     = AMP_W + VIDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [VIDX_W-1:0]  cfg_voice,
  input  logic [PHASE_W-1:0] cfg_incr,
  input  logic [2:0]         cfg_waveform,
  input  logic               cfg_enable,
  output logic [PHASE_W-1:0] pa_phase,
  output logic [2:0]         pa_waveform,
  input  logic [AMP_W-1:0]   pa_amplitude,
  output logic [MIX_W-1:0]   mix_out,
  output logic               mix_valid,
  output logic               busy,
  output logic               overrun,
  input  logic               overrun_clr
);

  localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);

  state_e             state_q;
  logic [VIDX_W-1:0]  idx_q;
  logic [MIX_W-1:0]   acc_q;
  logic [MIX_W-1:0]   acc_d;
  logic [PHASE_W-1:0] pa_phase_q;
  logic [2:0]         pa_waveform_q;
  logic [MIX_W-1:0]   mix_q;
  logic               mix_valid_q;
  logic               overrun_q;

  logic [PHASE_W-1:0] rd_phase;
  logic [2:0]         rd_waveform;
  logic               rd_enable;
  logic               adv_stb;

  // Enable is read before the edge, so a same-edge config write does not
  // affect this slot's contribution.
  assign acc_d   = acc_q + (rd_enable ? MIX_W'(pa_amplitude) : '0);
  assign adv_stb = (state_q == ACCUM) && rd_enable;

  osc_voice_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W),
    .VIDX_W     (VIDX_W)
  ) u_regfile (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_incr     (cfg_incr),
    .cfg_waveform (cfg_waveform),
    .cfg_enable   (cfg_enable),
    .rd_idx       (idx_q),
    .rd_phase     (rd_phase),
    .rd_waveform  (rd_waveform),
    .rd_enable    (rd_enable),
    .adv_stb      (adv_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      pa_phase_q    <= '0;
      pa_waveform_q <= '0;
      mix_q         <= '0;
      mix_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      mix_valid_q <= 1'b0;

      // Set is written last so it wins over a simultaneous clear.
      if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
      if (sample_tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (sample_tick) begin
            idx_q   <= '0;
            acc_q   <= '0;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          pa_phase_q    <= rd_phase;
          pa_waveform_q <= rd_waveform;
          state_q       <= ACCUM;
        end
        ACCUM: begin
          acc_q <= acc_d;
          if (idx_q == LAST_IDX) begin
            state_q <= OUTPUT;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= PRESENT;
          end
        end
        OUTPUT: begin
          mix_q       <= acc_q;
          mix_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pa_phase    = pa_phase_q;
  assign pa_waveform = pa_waveform_q;
  assign mix_out     = mix_q;
  assign mix_valid   = mix_valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_osc_voice_scheduler.sv
module tb_osc_voice_scheduler;
  import osc_pkg::*;

  localparam int NV = 4;
  localparam int PW = 32;
  localparam int AW = 12;
  localparam int VW = 2;
  localparam int MW = AW + VW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic [VW-1:0] cfg_voice = '0;
  logic [PW-1:0] cfg_incr = '0;
  logic [2:0]    cfg_waveform = '0;
  logic          cfg_enable = 1'b0;
  logic [PW-1:0] pa_phase;
  logic [2:0]    pa_waveform;
  logic [AW-1:0] pa_amplitude;
  logic [MW-1:0] mix_out;
  logic          mix_valid;
  logic          busy;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [MW-1:0] mix;
    int            at;
  } exp_t;
  exp_t exp_q[$];

  osc_voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW), .AMP_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .cfg_we       (cfg_we),
    .cfg_voice    (cfg_voice),
    .cfg_incr     (cfg_incr),
    .cfg_waveform (cfg_waveform),
    .cfg_enable   (cfg_enable),
    .pa_phase     (pa_phase),
    .pa_waveform  (pa_waveform),
    .pa_amplitude (pa_amplitude),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: squares are full-scale for the first part of the cycle.
  function automatic logic [AW-1:0] conv(input logic [PW-1:0] ph, input logic [2:0] wf);
    case (wf)
      WF_SQ50: return (ph < 32'h8000_0000) ? 12'hFFF : 12'h000;
      WF_SQ35: return (ph < 32'h5999_999A) ? 12'hFFF : 12'h000;
      WF_SQ15: return (ph < 32'h2666_6666) ? 12'hFFF : 12'h000;
      default: return ph[PW-1 -: AW];
    endcase
  endfunction

  always_comb pa_amplitude = conv(pa_phase, pa_waveform);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input int v, input logic [PW-1:0] incr,
                           input logic [2:0] wf, input logic en);
    cfg_we = 1'b1; cfg_voice = VW'(v); cfg_incr = incr;
    cfg_waveform = wf; cfg_enable = en;
    step();
    cfg_we = 1'b0;
  endtask

  // Issue a tick sampled at the next edge (edge 0); mix_valid is expected
  // to be seen in the cycle after edge 9.
  task automatic tick(input logic [MW-1:0] exp_mix, input bit expect_out);
    sample_tick = 1'b1;
    if (expect_out) exp_q.push_back('{mix: exp_mix, at: cyc + 10});
    step();
    sample_tick = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mix_out"}, 64'(mix_out), 64'h0);
    chk({tag, "_mix_valid"}, 64'(mix_valid), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_overrun"}, 64'(overrun), 64'h0);
    chk({tag, "_pa_phase"}, 64'(pa_phase), 64'h0);
    chk({tag, "_pa_waveform"}, 64'(pa_waveform), 64'h0);
  endtask

  // Monitor: every mix_valid cycle must match the oldest expected frame,
  // both in value and in arrival cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mix_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mix_valid: got mix_out 0x%0h at cycle %0d, required no valid", mix_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("mix_value", 64'(mix_out), 64'(e.mix));
          chk("mix_cycle", 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  initial begin
    // Reset and idle
    wait_cycles(3);
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    wait_cycles(20);
    chk_all_zero("idle");

    // Voice 0 sawtooth alone
    cfg_write(0, 32'h0100_0000, WF_SAW, 1'b1);
    tick(14'h0000, 1'b1);
    chk("busy_in_frame", 64'(busy), 64'h1);
    wait_cycles(19);
    tick(14'h0010, 1'b1);
    wait_cycles(12);
    chk("mix_hold", 64'(mix_out), 64'h0010);
    chk("busy_after_frame", 64'(busy), 64'h0);

    // All voices sq50 at half-cycle increment
    for (int v = 0; v < NV; v++) begin
      cfg_write(v, 32'h0, WF_SAW, 1'b0);
      cfg_write(v, 32'h8000_0000, WF_SQ50, 1'b1);
    end
    tick(14'h3FFC, 1'b1); wait_cycles(11);
    tick(14'h0000, 1'b1); wait_cycles(11);
    tick(14'h3FFC, 1'b1); wait_cycles(11);

    // Overrun: second tick at edge 3 is dropped
    tick(14'h0000, 1'b1);
    wait_cycles(2);
    sample_tick = 1'b1; step(); sample_tick = 1'b0;
    wait_cycles(10);
    chk("overrun_set", 64'(overrun), 64'h1);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("overrun_cleared", 64'(overrun), 64'h0);

    // Overrun set and clear on the same edge: set wins
    tick(14'h3FFC, 1'b1);
    wait_cycles(2);
    sample_tick = 1'b1; overrun_clr = 1'b1; step();
    sample_tick = 1'b0; overrun_clr = 1'b0;
    chk("overrun_set_wins", 64'(overrun), 64'h1);
    wait_cycles(10);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("overrun_cleared2", 64'(overrun), 64'h0);

    // Disable voice 0 during its ACCUM slot (edge 2)
    for (int v = 0; v < NV; v++) cfg_write(v, 32'h0, WF_SAW, 1'b0);
    cfg_write(0, 32'h4000_0000, WF_SAW, 1'b1);
    tick(14'h0000, 1'b1);
    step();
    cfg_we = 1'b1; cfg_voice = 2'd0; cfg_incr = 32'h4000_0000;
    cfg_waveform = WF_SAW; cfg_enable = 1'b0;
    step();
    cfg_we = 1'b0;
    wait_cycles(10);
    cfg_write(0, 32'h4000_0000, WF_SAW, 1'b1);
    tick(14'h0000, 1'b1); wait_cycles(11);
    tick(14'h0400, 1'b1); wait_cycles(11);

    // Voice 2 sq15 joins; voice 0 saw at phase 0x8000_0000
    cfg_write(2, 32'h1000_0000, WF_SQ15, 1'b1);
    tick(14'h17FF, 1'b1); wait_cycles(11);

    // Reset at edge 5 of a frame
    tick(14'h0000, 1'b0);
    wait_cycles(5);
    chk("pre_reset_pa_phase", 64'(pa_phase), 64'h1000_0000);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(12);
    chk("post_reset_busy", 64'(busy), 64'h0);

    // Clean frame after reset: only voice 1 enabled
    cfg_write(1, 32'h0000_0001, WF_SQ50, 1'b1);
    tick(14'h0FFF, 1'b1); wait_cycles(12);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/osc_voice_scheduler.md
Name: osc_voice_scheduler

Overview:
- Time-multiplexes one shared phase-to-amplitude converter across NUM_VOICES oscillator voices.
- Per voice, holds the phase accumulator, the phase increment, the waveform select and an enable bit.
- On each sample tick it walks the voices in order: presents each voice's phase and waveform to the converter, captures the returned amplitude, and advances that voice's phase.
- Emits the summed mix with a one-cycle valid pulse. It sits between the control/config interface and the audio output path.

Parameters:
- NUM_VOICES, 4, number of voices (power of two, at least 2)
- PHASE_W, 32, phase accumulator and increment width
- AMP_W, 12, converter amplitude width
- VIDX_W, clog2(NUM_VOICES), voice index width (derived)
- MIX_W, AMP_W+VIDX_W, mix output width (derived)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle pulse at the sample rate
- cfg_we  in  1  config write strobe
- cfg_voice  in  VIDX_W  voice addressed by the write
- cfg_incr  in  PHASE_W  phase increment
- cfg_waveform  in  3  waveform code (001 sq50, 010 sq35, 011 sq15, other saw)
- cfg_enable  in  1  voice enable
- pa_phase  out  PHASE_W  registered phase to the converter
- pa_waveform  out  3  registered waveform to the converter
- pa_amplitude  in  AMP_W  combinational converter result
- mix_out  out  MIX_W  unsigned sum of enabled-voice amplitudes
- mix_valid  out  1  one-cycle pulse when mix_out updates
- busy  out  1  high whenever state is not IDLE
- overrun  out  1  sticky flag: a tick arrived while busy
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async, rst_n=0): all of the following go to 0.
  - phase[], incr[], waveform[], enable[]
  - pa_phase, pa_waveform
  - accumulator, voice index, mix_out, mix_valid, overrun
  - state goes to IDLE, so busy=0.
- Reset mid-frame aborts the frame; no mix_valid is produced.
- FSM states: IDLE, PRESENT, ACCUM, OUTPUT.
  - IDLE: on sample_tick, set idx=0, clear acc, go to PRESENT.
  - PRESENT: pa_phase<=phase[idx], pa_waveform<=waveform[idx]; go to ACCUM.
  - ACCUM:
    - acc += enable[idx] ? pa_amplitude : 0
    - if enable[idx], phase[idx] += incr[idx], modulo 2^PHASE_W with silent wrap
    - if idx==NUM_VOICES-1, go to OUTPUT; else idx++ and go to PRESENT
  - OUTPUT: mix_out<=acc, mix_valid<=1 for exactly one cycle; go to IDLE.
- Timing: call the edge that samples sample_tick in IDLE edge 0.
  - Voice v is presented at edge 2v+1 and accumulated at edge 2v+2.
  - mix_valid is high in the cycle after edge 2*NUM_VOICES+1, i.e. edge 9 for N=4.
  - The minimum tick spacing is 2N+2 cycles.
- mix_out holds its value between frames. The mix cannot overflow, because MIX_W covers N*(2^AMP_W-1).
- sample_tick while busy (including in OUTPUT): the tick is ignored and overrun<=1. overrun_clr clears the flag. If the clear and a set occur in the same cycle, the set wins.
- A sample_tick in IDLE is never dropped.
- Config write (cfg_we=1):
  - incr, waveform and enable for cfg_voice update at the next edge.
  - If cfg_enable=0, phase[cfg_voice] is also cleared to 0, so re-enable starts at phase 0.
- Config write during a frame:
  - A voice already presented keeps the values it was presented with.
  - In ACCUM, the incr/enable used are the register values before that edge.
  - A write that clears enable in the same edge as that voice's ACCUM update: the clear to 0 wins.
- Disabled voices contribute 0 and their phase stays frozen at 0. They are still presented, so slot timing is constant.

Decomposition:
- Shared package osc_pkg:
  - state enum (IDLE, PRESENT, ACCUM, OUTPUT)
  - waveform code constants WF_SQ50=3'b001, WF_SQ35=3'b010, WF_SQ15=3'b011, WF_SAW=3'b000
  - default NUM_VOICES/PHASE_W/AMP_W constants
- One sub-module, osc_voice_regfile:
  - holds the per-voice phase/incr/waveform/enable arrays
  - provides the config write port, a read port by idx, and a phase-advance strobe with the clear-wins rule
- The FSM, accumulator and output registers stay in osc_voice_scheduler.
- The converter is instantiated by the parent and wired to the pa_* ports.

Test Plan:
- Reset then idle for 20 cycles with no tick -> all outputs 0, busy=0, mix_valid never high.
- Voice0: incr=0x0100_0000, waveform=saw, enabled; others disabled; two ticks spaced 20 cycles apart, bench models the converter -> first mix_out=0x000 with mix_valid at edge 9; second mix_out=0x010.
- All 4 voices: waveform=001, incr=0x8000_0000, enabled; three ticks -> mix_out=0x3FFC, then 0x0000, then 0x3FFC (phase wrap).
- Tick at edge 0 and again at edge 3 -> overrun=1, exactly one mix_valid at edge 9; overrun_clr pulse -> overrun=0.
- Disable voice0 via a cfg write during its ACCUM slot -> phase[0]=0, voice0 contributes 0 in that frame, re-enable restarts at phase 0.
- Assert rst_n=0 at edge 5 of a frame -> all outputs 0 immediately, no mix_valid; the next tick runs a clean frame.
